uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer between the AXI4-Lite UART register block and the uart core's TX interface.
- Accepts byte writes from the register block and holds them in a power-of-two circular FIFO.
- Launches one byte at a time into the uart core using its TX_DRDY/TX_DI/TX_BUSY/TX_DONE handshake.
- Lets software queue bursts without polling TX_BUSY for every byte.

Parameters:
- DATA_BITS, 8: width of each stored byte; must match the uart core's DATA_BITS.
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries (16); legal range 1..8.
- ACK_TIMEOUT, 15: cycles to wait for TX_BUSY after a launch before giving up; range 1..255.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- WR_EN  in  1  push strobe from the register block; one byte per cycle.
- WR_DATA  in  DATA_BITS  byte to push.
- FULL  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- EMPTY  out  1  FIFO holds 0 entries.
- LEVEL  out  DEPTH_LOG2+1  current entry count.
- OVERFLOW  out  1  sticky: a push was attempted while full.
- CLR_OVF  in  1  clears OVERFLOW.
- TX_DRDY  out  1  one-cycle launch pulse to the uart core.
- TX_DI  out  DATA_BITS  byte presented to the uart core; held stable until the next launch.
- TX_BUSY  in  1  uart core is transmitting.
- TX_DONE  in  1  uart core finished a frame (one-cycle pulse).
- IDLE  out  1  FIFO empty and no transmission in progress.
- IRQ  out  1  empty-interrupt pulse (see Optional Feature).

Behaviour:
- Everything is synchronous to CLK.
- Reset values while RST=1:
  - Pointers, LEVEL and OVERFLOW cleared to 0.
  - TX_DRDY=0, TX_DI=0, IRQ=0.
  - EMPTY=1, FULL=0, IDLE=1.
  - FSM goes to S_IDLE.
  - Storage contents are don't-care.
- A reset in the middle of a transmission drops all queued bytes. A byte already handed to the uart core is not recalled.
- Storage is a DEPTH-entry array with wr_ptr and rd_ptr of DEPTH_LOG2 bits each. Pointers wrap modulo DEPTH with no special case. LEVEL is a separate counter.
- Push:
  - Taken when WR_EN=1 and FULL=0: mem[wr_ptr]<=WR_DATA, wr_ptr+1.
  - WR_EN=1 while FULL=1: data discarded, OVERFLOW<=1.
  - The full check uses the FULL value before the clock edge. A push is rejected when full even if a pop occurs in the same cycle.
- Pop occurs only on the FSM launch edge.
- LEVEL update per edge: +1 on push only, -1 on pop only, unchanged on push and pop together. FULL, EMPTY and LEVEL are registered and reflect the edge just taken.
- OVERFLOW: set has priority over CLR_OVF in the same cycle.
- FSM states:
  - S_IDLE: if EMPTY=0 and TX_BUSY=0, then on that edge TX_DI<=mem[rd_ptr], rd_ptr+1, LEVEL-1, TX_DRDY<=1, go to S_LAUNCH. Otherwise stay.
  - S_LAUNCH: TX_DRDY<=0, clear the timeout counter, go to S_WAIT_ACK. TX_DRDY is therefore high for exactly one cycle.
  - S_WAIT_ACK: on TX_BUSY=1 go to S_WAIT_DONE. If the counter reaches ACK_TIMEOUT, go to S_IDLE; the byte counts as sent and is not retried. Otherwise increment the counter.
  - S_WAIT_DONE: on TX_DONE=1 or TX_BUSY=0, go to S_IDLE.
- Latency:
  - A push into an empty FIFO while the uart is idle produces TX_DRDY=1 in the second cycle after the WR_EN edge (push edge, then launch edge).
  - Back-to-back bytes: the next launch happens at the earliest one cycle after S_WAIT_DONE exits.
- IDLE = EMPTY and state==S_IDLE and TX_BUSY=0 (combinational).

Optional Feature:
- Macro: UART_TX_FIFO_IRQ_EN.
- Defined:
  - IRQ pulses high for exactly one cycle on the edge where the FSM goes S_WAIT_DONE -> S_IDLE with EMPTY=1, i.e. the last queued byte has finished.
  - A push in that same cycle suppresses the pulse.
- Not defined: IRQ is tied to 0 and no extra logic is inferred.

Test Plan:
- Single byte: reset, then WR_EN one cycle with 0xA5; the uart core model raises TX_BUSY 1 cycle after TX_DRDY and holds it 20 cycles, then pulses TX_DONE.
  -> TX_DRDY high 1 cycle, 2 cycles after the push; TX_DI=0xA5; LEVEL goes 0->1->0; IDLE returns to 1; IRQ pulses once (macro on).
- Burst to full, DEPTH=16 with TX_BUSY forced 1: push 17 bytes 0x00..0x10.
  -> FULL=1 after the 16th; 17th discarded; OVERFLOW=1; LEVEL=16. Release TX_BUSY: bytes 0x00..0x0F appear in order on TX_DI; 0x10 never appears.
- Wrap-around: push 10, drain 10, push 10, drain 10.
  -> Order preserved across the pointer wrap; LEVEL never exceeds 10.
- Simultaneous push and pop at LEVEL=3.
  -> LEVEL stays 3; CLR_OVF asserted together with an overflowing push leaves OVERFLOW=1.
- Ack timeout: TX_BUSY held 0 after the launch.
  -> FSM returns to S_IDLE after ACK_TIMEOUT=15 cycles; the next byte launches; the failed byte is not resent.
- Mid-transfer reset: RST=1 while in S_WAIT_DONE with LEVEL=5.
  -> Next cycle LEVEL=0, EMPTY=1, TX_DRDY=0, OVERFLOW=0; no further launches.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the uart core's TX_DRDY/TX_DI/TX_BUSY/TX_DONE handshake.
// Define UART_TX_FIFO_IRQ_EN to enable the end-of-burst IRQ pulse; otherwise IRQ is tied low.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_BITS-1:0]  WR_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  input  logic                  CLR_OVF,
  output logic                  TX_DRDY,
  output logic [DATA_BITS-1:0]  TX_DI,
  input  logic                  TX_BUSY,
  input  logic                  TX_DONE,
  output logic                  IDLE,
  output logic                  IRQ
);

  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [CNT_W-1:0]       ack_cnt;
  logic [CNT_W-1:0]       ack_cnt_nxt;
  logic                   tx_drdy_nxt;
  logic                   push_c;
  logic                   pop_c;
  logic [LVL_W-1:0]       level_nxt_c;

  // A push is judged against FULL as it stood before the edge, even if a pop happens too.
  assign push_c = WR_EN & ~FULL;

  assign IDLE = EMPTY & (state == S_IDLE) & ~TX_BUSY;

  // Launch sequencer: next state, launch strobe and ack-timeout counter.
  always_comb begin
    state_nxt   = state;
    tx_drdy_nxt = 1'b0;
    ack_cnt_nxt = ack_cnt;
    pop_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!EMPTY && !TX_BUSY) begin
          pop_c       = 1'b1;
          tx_drdy_nxt = 1'b1;
          state_nxt   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        ack_cnt_nxt = '0;
        state_nxt   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (TX_BUSY) begin
          state_nxt = S_WAIT_DONE;
        end else if (ack_cnt == CNT_W'(ACK_TIMEOUT)) begin
          // Unacknowledged byte is treated as sent; no retry.
          state_nxt = S_IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (TX_DONE || !TX_BUSY) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Occupancy after this edge.
  always_comb begin
    level_nxt_c = LEVEL;
    if (push_c && !pop_c) begin
      level_nxt_c = LEVEL + LVL_W'(1);
    end else if (!push_c && pop_c) begin
      level_nxt_c = LEVEL - LVL_W'(1);
    end
  end

  // State register and launch outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      ack_cnt <= '0;
      TX_DRDY <= 1'b0;
      TX_DI   <= '0;
    end else begin
      state   <= state_nxt;
      ack_cnt <= ack_cnt_nxt;
      TX_DRDY <= tx_drdy_nxt;
      if (pop_c) begin
        TX_DI <= mem[rd_ptr];
      end
    end
  end

  // Storage is not reset; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (push_c && !RST) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  // Pointers and occupancy flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
      FULL   <= 1'b0;
      EMPTY  <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      LEVEL <= level_nxt_c;
      FULL  <= (level_nxt_c == LVL_W'(DEPTH));
      EMPTY <= (level_nxt_c == '0);
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
    end else if (WR_EN && FULL) begin
      OVERFLOW <= 1'b1;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_nxt_c;

  // Last queued byte finished and nothing new arrived on the same edge.
  assign irq_nxt_c = (state == S_WAIT_DONE) & (TX_DONE | ~TX_BUSY) & EMPTY & ~push_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= irq_nxt_c;
    end
  end
`else
  assign IRQ = 1'b0;
`endif

endmodule
